// File: rtl/softmax_normalizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_pkg
//  Brief    : Shared sizes, constants, FSM encoding and the lane
//             multiply-shift-saturate helper for the softmax normalizer.
//  Revision : 1.0 - initial release
// ============================================================================
package softmax_pkg;

  localparam int D_MODEL     = 64;
  localparam int IN_W        = 16;
  localparam int SUM_W       = 24;
  localparam int RECIP_W     = 25;
  localparam int LANES       = 8;
  localparam int GROUPS      = D_MODEL / LANES;
  localparam int GRP_W       = $clog2(GROUPS);
  localparam int LANE_W      = $clog2(LANES);
  localparam int PROD_W      = IN_W + RECIP_W;
  localparam int RECIP_SHIFT = 14;
  localparam int DIV_CNT_W   = 5;

  localparam logic [IN_W-1:0] SAT_MAX = 16'h7FFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SUM = 3'd1,
    ST_DIVIDE   = 3'd2,
    ST_SCALE    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // p = (e * R) >> RECIP_SHIFT, clamped to the largest positive S5.10 value
  function automatic logic [IN_W-1:0] scale_sat(input logic [IN_W-1:0]    e,
                                                input logic [RECIP_W-1:0] r);
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_shifted;
    w_prod    = PROD_W'(e) * PROD_W'(r);
    w_shifted = w_prod >> RECIP_SHIFT;
    if (w_shifted > PROD_W'(SAT_MAX)) begin
      return SAT_MAX;
    end
    return w_shifted[IN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/softmax_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_normalizer_if
//  Brief    : Exp-vector / sum / probability bus of the softmax normalizer.
//             master = upstream producer side, slave = normalizer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface softmax_normalizer_if;
  import softmax_pkg::*;

  logic                       exp_valid;
  logic [D_MODEL*IN_W-1:0]    exp_values_in;
  logic                       sum_valid;
  logic [SUM_W-1:0]           sum_in;
  logic                       busy;
  logic                       prob_valid;
  logic [D_MODEL*IN_W-1:0]    prob_out;
  logic                       sum_err;
  logic                       overrun;

  modport master (
    output exp_valid, exp_values_in, sum_valid, sum_in,
    input  busy, prob_valid, prob_out, sum_err, overrun
  );

  modport slave (
    input  exp_valid, exp_values_in, sum_valid, sum_in,
    output busy, prob_valid, prob_out, sum_err, overrun
  );

endinterface
`default_nettype wire

// File: rtl/softmax_normalizer_recip_divider.sv
`default_nettype none
// ============================================================================
//  Module   : recip_divider
//  Brief    : Restoring divider computing floor(2^24 / divisor), one quotient
//             bit per cycle, 25 cycles after start. done is high during the
//             final iteration cycle, so quotient is final right after that edge.
//  Revision : 1.0 - initial release
// ============================================================================
module recip_divider
  import softmax_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SUM_W-1:0]     divisor,
  output logic [RECIP_W-1:0]   quotient,
  output logic                 done
);

  logic [SUM_W-1:0]     r_rem;
  logic [RECIP_W-1:0]   r_quo;
  logic [SUM_W-1:0]     r_div;
  logic [DIV_CNT_W-1:0] r_cnt;

  logic [RECIP_W-1:0]   w_trial;
  logic [RECIP_W-1:0]   w_diff;
  logic                 w_fits;

  // Trial subtraction; the remainder is always below the divisor, so the
  // difference borrows into its top bit exactly when the divisor does not fit
  always_comb begin
    w_trial = {r_rem, r_quo[RECIP_W-1]};
    w_diff  = w_trial - {1'b0, r_div};
    w_fits  = ~w_diff[RECIP_W-1];
  end

  // Load the dividend on start, then shift one quotient bit in per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_rem <= '0;
      r_quo <= RECIP_W'(1) << (RECIP_W - 1);
      r_div <= divisor;
      r_cnt <= DIV_CNT_W'(RECIP_W);
    end else if (r_cnt != '0) begin
      r_rem <= w_fits ? w_diff[SUM_W-1:0] : w_trial[SUM_W-1:0];
      r_quo <= {r_quo[RECIP_W-2:0], w_fits};
      r_cnt <= r_cnt - DIV_CNT_W'(1);
    end
  end

  assign quotient = r_quo;
  assign done     = (r_cnt == DIV_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/softmax_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_normalizer
//  Brief    : Latches 64 exp values, waits for their sum S, computes
//             R = floor(2^24/S) and scales the vector by R eight lanes per
//             cycle into a 64-element S5.10 probability vector.
//  Revision : 1.0 - initial release
// ============================================================================
module softmax_normalizer
  import softmax_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  softmax_normalizer_if.slave   bus
);

  state_t                         r_state;
  state_t                         w_next;
  logic [D_MODEL-1:0][IN_W-1:0]   r_vec;
  logic [D_MODEL-1:0][IN_W-1:0]   r_prob;
  logic [GRP_W-1:0]               r_grp;
  logic                           r_err;
  logic                           r_overrun;

  logic                           w_sum_pos;
  logic                           w_sum_take;
  logic                           w_sum_bad;
  logic                           w_div_done;
  logic [RECIP_W-1:0]             w_recip;
  logic [LANES-1:0][IN_W-1:0]     w_lane;

  assign w_sum_pos  = ~bus.sum_in[SUM_W-1] && (bus.sum_in != '0);
  assign w_sum_take = (r_state == ST_WAIT_SUM) && bus.sum_valid && w_sum_pos;
  assign w_sum_bad  = (r_state == ST_WAIT_SUM) && bus.sum_valid && !w_sum_pos;

  recip_divider u_recip_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_sum_take),
    .divisor  (bus.sum_in),
    .quotient (w_recip),
    .done     (w_div_done)
  );

  // Eight multiply-shift-saturate lanes working on the current group
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane[l] = scale_sat(r_vec[{r_grp, LANE_W'(l)}], w_recip);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (bus.exp_valid) w_next = ST_WAIT_SUM;
      ST_WAIT_SUM: if (w_sum_take) w_next = ST_DIVIDE;
                   else if (w_sum_bad) w_next = ST_DONE;
      ST_DIVIDE:   if (w_div_done) w_next = ST_SCALE;
      ST_SCALE:    if (r_grp == GRP_W'(GROUPS - 1)) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    bus.busy       = (r_state != ST_IDLE);
    bus.prob_valid = (r_state == ST_DONE);
    bus.sum_err    = (r_state == ST_DONE) && r_err;
  end

  // Vector buffer: written only on acceptance, negative exps stored as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
    end else if ((r_state == ST_IDLE) && bus.exp_valid) begin
      for (int i = 0; i < D_MODEL; i++) begin
        r_vec[i] <= bus.exp_values_in[i*IN_W + IN_W - 1] ? '0
                                                         : bus.exp_values_in[i*IN_W +: IN_W];
      end
    end
  end

  // Result vector: cleared on a bad sum, one group written per SCALE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prob <= '0;
    end else if (w_sum_bad) begin
      r_prob <= '0;
    end else if (r_state == ST_SCALE) begin
      for (int l = 0; l < LANES; l++) begin
        r_prob[{r_grp, LANE_W'(l)}] <= w_lane[l];
      end
    end
  end

  // Group counter wraps back to zero after the last group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_grp <= '0;
    else if (r_state == ST_SCALE)  r_grp <= r_grp + GRP_W'(1);
    else                           r_grp <= '0;
  end

  // Remember which sum path led to DONE, and flag strobes that arrive while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT_SUM) && bus.sum_valid) r_err <= !w_sum_pos;
      r_overrun <= bus.exp_valid && (r_state != ST_IDLE);
    end
  end

  assign bus.prob_out = r_prob;
  assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_softmax_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softmax_normalizer
//  Brief    : Self-checking bench for softmax_normalizer with a reciprocal
//             and scaling reference model, directed and randomized vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_normalizer;
  import softmax_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_normalizer_if bus ();

  softmax_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Expected schedule and result of the run in flight
  logic [1023:0] m_prob    = '0;
  bit            m_err     = 1'b0;
  int            m_pv      = -1;
  int            m_ovr     = -1;
  int            m_busy_lo = 1;
  int            m_busy_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int first;
    tests++;
    if (act !== exp) begin
      fails++;
      first = 0;
      for (int i = 63; i >= 0; i--) if (act[i*16 +: 16] !== exp[i*16 +: 16]) first = i;
      $display("FAIL %s @cyc %0d: element %0d got %h expected %h", name, cyc, first,
               act[first*16 +: 16], exp[first*16 +: 16]);
    end
  endtask

  // Reference: probability_i = min(0x7FFF, floor(e_i * floor(2^24/S) / 2^14))
  function automatic logic [1023:0] model(input logic [1023:0] v, input logic [23:0] s,
                                          output bit err);
    logic [1023:0] res;
    longint        r, e, p;
    res = '0;
    err = (s[23] == 1'b1) || (s == 24'd0);
    if (!err) begin
      r = 64'h1000000 / longint'(s);
      for (int i = 0; i < 64; i++) begin
        e = v[i*16 + 15] ? 0 : longint'(v[i*16 +: 16]);
        p = (e * r) / 16384;
        res[i*16 +: 16] = (p > 32767) ? 16'h7FFF : 16'(p);
      end
    end
    return res;
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 4))
        0:       v[i*16 +: 16] = 16'h8000 | 16'($urandom);
        1:       v[i*16 +: 16] = 16'($urandom_range(0, 32767));
        default: v[i*16 +: 16] = 16'($urandom_range(0, 2047));
      endcase
    end
    return v;
  endfunction

  function automatic logic [23:0] rand_sum();
    case ($urandom_range(0, 5))
      0:       return 24'($urandom_range(1, 64));
      1:       return 24'($urandom_range(1, 1 << 20));
      2:       return 24'h800000 | 24'($urandom);
      3:       return 24'd0;
      4:       return 24'($urandom_range(1, 24'h7FFFFF));
      default: return 24'd65536;
    endcase
  endfunction

  // Cycle-by-cycle comparison of the DUT outputs against the expected schedule
  always @(negedge clk) begin
    chk("prob_valid", 32'(bus.prob_valid), 32'(cyc == m_pv));
    chk("busy", 32'(bus.busy), 32'(cyc >= m_busy_lo && cyc <= m_busy_hi));
    chk("overrun", 32'(bus.overrun), 32'(cyc == m_ovr));
    if (cyc == m_pv) begin
      chk("sum_err", 32'(bus.sum_err), 32'(m_err));
      chk_vec("prob_out", bus.prob_out, m_prob);
    end else begin
      chk("sum_err_quiet", 32'(bus.sum_err), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string name);
    chk_vec({name, "_prob_out"}, bus.prob_out, '0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_prob_valid"}, 32'(bus.prob_valid), 32'd0);
    chk({name, "_sum_err"}, 32'(bus.sum_err), 32'd0);
    chk({name, "_overrun"}, 32'(bus.overrun), 32'd0);
  endtask

  // One vector transaction. ovr_at>0 pulses exp_valid that many cycles into
  // the computation; abort_at>0 asserts reset that many cycles after the sum.
  task automatic run(input logic [1023:0] vec, input logic [23:0] s,
                     input int ovr_at, input bit same, input int abort_at);
    bit err;
    int gap, sum_cyc, guard;
    @(posedge clk); #1;
    bus.exp_valid     = 1'b1;
    bus.exp_values_in = vec;
    bus.sum_valid     = same;
    bus.sum_in        = 24'd1;
    m_busy_lo = cyc + 1;
    m_busy_hi = 32'h7FFFFFFF;
    m_pv      = -1;
    @(posedge clk); #1;
    bus.exp_valid     = 1'b0;
    bus.sum_valid     = 1'b0;
    bus.exp_values_in = {32{$urandom}};
    gap = $urandom_range(0, 3);
    repeat (gap) begin @(posedge clk); #1; end
    bus.sum_valid = 1'b1;
    bus.sum_in    = s;
    m_prob  = model(vec, s, err);
    m_err   = err;
    sum_cyc = cyc;
    m_pv      = cyc + (err ? 1 : 34);
    m_busy_hi = m_pv;
    @(posedge clk); #1;
    bus.sum_valid = 1'b0;
    if (abort_at > 0) begin
      while (cyc < sum_cyc + abort_at) begin @(posedge clk); #1; end
      rst_n     = 1'b0;
      m_pv      = -1;
      m_busy_hi = cyc - 1;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      return;
    end
    if (ovr_at > 0 && !err) begin
      repeat (ovr_at - 1) begin @(posedge clk); #1; end
      bus.exp_valid     = 1'b1;
      bus.exp_values_in = ~vec;
      m_ovr = cyc + 1;
      @(posedge clk); #1;
      bus.exp_valid = 1'b0;
    end
    guard = 0;
    while (cyc <= m_pv && guard < 100) begin @(posedge clk); guard++; end
    #1;
    if (guard >= 100) chk("run_timeout", 32'd1, 32'd0);
  endtask

  logic [1023:0] uni, onehot, satv;

  initial begin
    bus.exp_valid     = 1'b0;
    bus.exp_values_in = '0;
    bus.sum_valid     = 1'b0;
    bus.sum_in        = '0;
    uni    = {64{16'd1024}};
    onehot = '0;
    onehot[15:0] = 16'd1024;
    satv   = '0;
    satv[15:0]   = 16'h7FFF;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run(uni, 24'd65536, 0, 1'b0, 0);
    chk("uni_e0", 32'(bus.prob_out[15:0]), 32'd16);
    chk("uni_e63", 32'(bus.prob_out[1023:1008]), 32'd16);

    run(onehot, 24'd1024, 0, 1'b0, 0);
    chk("onehot_e0", 32'(bus.prob_out[15:0]), 32'd1024);
    chk("onehot_e1", 32'(bus.prob_out[31:16]), 32'd0);

    run(satv, 24'd1, 0, 1'b0, 0);
    chk("sat_e0", 32'(bus.prob_out[15:0]), 32'h7FFF);

    run(uni, 24'h800000, 0, 1'b0, 0);
    chk_vec("neg_sum_clear", bus.prob_out, '0);
    run(uni, 24'd65536, 0, 1'b0, 0);
    run(uni, 24'd0, 0, 1'b0, 0);
    chk_vec("zero_sum_clear", bus.prob_out, '0);

    run(uni, 24'd65536, 3, 1'b0, 0);
    chk("ovr_uni_e5", 32'(bus.prob_out[95:80]), 32'd16);

    run(uni, 24'd65536, 0, 1'b0, 29);
    run(uni, 24'd65536, 0, 1'b0, 0);
    chk("post_abort_e7", 32'(bus.prob_out[127:112]), 32'd16);

    run(rand_vec(), 24'd4096, 0, 1'b1, 0);

    for (int k = 0; k < 14; k++) begin
      run(rand_vec(), rand_sum(), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0,
          1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
